// File: rtl/core_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : core_run_ctrl_if
// Brief    : Run-request / PC-monitor / completion-status bundle between the
//            run controller (slave) and the bench or bring-up logic (master).
// Revision : 1.0
// ============================================================================
interface core_run_ctrl_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    logic             start;
    logic [PC_W-1:0]  PC_in;
    logic             core_rst_n;
    logic             running;
    logic             done;
    logic             halt_ok;
    logic             timeout;
    logic [CNT_W-1:0] cycle_cnt;
    logic [PC_W-1:0]  halt_pc;

    modport master (
        output start,
        output PC_in,
        input  core_rst_n,
        input  running,
        input  done,
        input  halt_ok,
        input  timeout,
        input  cycle_cnt,
        input  halt_pc
    );

    modport slave (
        input  start,
        input  PC_in,
        output core_rst_n,
        output running,
        output done,
        output halt_ok,
        output timeout,
        output cycle_cnt,
        output halt_pc
    );
endinterface
`default_nettype wire

// File: rtl/core_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : core_run_ctrl
// Brief    : Start / reset-hold / run / done sequencer for a core; ends a run
//            on a PC self-loop (halt) or on cycle-budget exhaustion (timeout).
// Revision : 1.0
// ============================================================================
module core_run_ctrl #(
    parameter int PC_W        = 32,
    parameter int CNT_W       = 32,
    parameter int RST_CYCLES  = 4,
    parameter int HALT_REPEAT = 3,
    parameter int MAX_CYCLES  = 300
) (
    input  wire logic     clk,
    input  wire logic     RST,
    core_run_ctrl_if.slave bus
);
    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int SAME_W = $clog2(HALT_REPEAT + 1);

    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [SAME_W-1:0] c_HALT_LAST = SAME_W'(HALT_REPEAT - 1);
    localparam logic [CNT_W-1:0]  c_MAX       = CNT_W'(MAX_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q,      state_d;
    logic [HOLD_W-1:0] hold_cnt_q,   hold_cnt_d;
    logic [CNT_W-1:0]  cycle_cnt_q,  cycle_cnt_d;
    logic [PC_W-1:0]   prev_pc_q,    prev_pc_d;
    logic              prev_valid_q, prev_valid_d;
    logic [SAME_W-1:0] same_cnt_q,   same_cnt_d;
    logic              halt_ok_q,    halt_ok_d;
    logic              timeout_q,    timeout_d;
    logic [PC_W-1:0]   halt_pc_q,    halt_pc_d;
    logic              core_rst_n_q, core_rst_n_d;
    logic              running_q,    running_d;
    logic              done_q,       done_d;

    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_match;

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        cycle_cnt_d  = cycle_cnt_q;
        prev_pc_d    = prev_pc_q;
        prev_valid_d = prev_valid_q;
        same_cnt_d   = same_cnt_q;
        halt_ok_d    = halt_ok_q;
        timeout_d    = timeout_q;
        halt_pc_d    = halt_pc_q;
        w_cnt_next   = cycle_cnt_q + CNT_W'(1);
        w_match      = prev_valid_q && (bus.PC_in == prev_pc_q);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == c_HOLD_LAST) begin
                    state_d      = S_RUN;
                    cycle_cnt_d  = '0;
                    same_cnt_d   = '0;
                    prev_valid_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            S_RUN: begin
                cycle_cnt_d  = w_cnt_next;
                same_cnt_d   = w_match ? (same_cnt_q + SAME_W'(1)) : '0;
                prev_pc_d    = bus.PC_in;
                prev_valid_d = 1'b1;
                // Halt is tested first so it takes priority on the budget's last cycle.
                if (w_match && (same_cnt_q == c_HALT_LAST)) begin
                    state_d   = S_DONE;
                    halt_ok_d = 1'b1;
                    halt_pc_d = bus.PC_in;
                end else if (w_cnt_next == c_MAX) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                    halt_pc_d = '0;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                    halt_ok_d  = 1'b0;
                    timeout_d  = 1'b0;
                    halt_pc_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they track it with no comb path.
        running_d    = (state_d == S_RUN);
        done_d       = (state_d == S_DONE);
        core_rst_n_d = (state_d == S_RUN) || (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q      <= S_IDLE;
            hold_cnt_q   <= '0;
            cycle_cnt_q  <= '0;
            prev_pc_q    <= '0;
            prev_valid_q <= 1'b0;
            same_cnt_q   <= '0;
            halt_ok_q    <= 1'b0;
            timeout_q    <= 1'b0;
            halt_pc_q    <= '0;
            core_rst_n_q <= 1'b0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            prev_pc_q    <= prev_pc_d;
            prev_valid_q <= prev_valid_d;
            same_cnt_q   <= same_cnt_d;
            halt_ok_q    <= halt_ok_d;
            timeout_q    <= timeout_d;
            halt_pc_q    <= halt_pc_d;
            core_rst_n_q <= core_rst_n_d;
            running_q    <= running_d;
            done_q       <= done_d;
        end
    end

    assign bus.core_rst_n = core_rst_n_q;
    assign bus.running    = running_q;
    assign bus.done       = done_q;
    assign bus.halt_ok    = halt_ok_q;
    assign bus.timeout    = timeout_q;
    assign bus.cycle_cnt  = cycle_cnt_q;
    assign bus.halt_pc    = halt_pc_q;
endmodule
`default_nettype wire

// File: tb/tb_core_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_run_ctrl
// Brief    : Randomized scoreboard bench for core_run_ctrl with a run-length
//            reference model of halt / timeout outcomes.
// Revision : 1.0
// ============================================================================
module tb_core_run_ctrl;
    localparam int PC_W        = 32;
    localparam int CNT_W       = 32;
    localparam int RST_CYCLES  = 4;
    localparam int HALT_REPEAT = 3;
    localparam int MAX_CYCLES  = 300;

    logic clk = 1'b0;
    logic RST;
    always #5 clk = ~clk;

    core_run_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    core_run_ctrl #(
        .PC_W        (PC_W),
        .CNT_W       (CNT_W),
        .RST_CYCLES  (RST_CYCLES),
        .HALT_REPEAT (HALT_REPEAT),
        .MAX_CYCLES  (MAX_CYCLES)
    ) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus.slave)
    );

    typedef struct {
        bit               halt_ok;
        bit               timeout;
        logic [PC_W-1:0]  halt_pc;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t            sb[$];
    exp_t            mon_e;
    int              n_cmp = 0;
    int              n_err = 0;
    logic [PC_W-1:0] seq [MAX_CYCLES];
    bit              done_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input bit h, input bit t, input int pc, input int cnt);
        exp_t e;
        e.halt_ok = h;
        e.timeout = t;
        e.halt_pc = PC_W'(pc);
        e.cnt     = CNT_W'(cnt);
        return e;
    endfunction

    // A halt needs HALT_REPEAT+1 identical consecutive samples; else the budget runs out.
    function automatic exp_t model();
        exp_t e;
        int   run_len;
        e = mk(1'b0, 1'b1, 0, MAX_CYCLES);
        run_len = 0;
        for (int i = 0; i < MAX_CYCLES; i++) begin
            run_len = (i > 0 && seq[i] == seq[i-1]) ? run_len + 1 : 1;
            if (run_len == HALT_REPEAT + 1) begin
                e = mk(1'b1, 1'b0, int'(seq[i]), i + 1);
                return e;
            end
        end
        return e;
    endfunction

    task automatic fill_halt_demo();
        for (int i = 0; i < MAX_CYCLES; i++) seq[i] = PC_W'((i < 3) ? 4 * i : 12);
    endtask

    task automatic fill_inc(input int stop);
        for (int i = 0; i < MAX_CYCLES; i++) seq[i] = PC_W'(4 * ((i < stop) ? i : stop));
    endtask

    task automatic fill_near_miss();
        for (int i = 0; i < MAX_CYCLES; i++) seq[i] = PC_W'((i == 0) ? 0 : (i < 4) ? 8 : 4);
    endtask

    task automatic fill_rand(input int alph);
        for (int i = 0; i < MAX_CYCLES; i++) seq[i] = PC_W'(4 * $urandom_range(0, alph - 1));
    endtask

    // One complete run from IDLE or DONE; abort_at >= 0 applies RST at that RUN cycle.
    task automatic do_run(input bit use_lit, input exp_t lit, input int abort_at, input int gap);
        exp_t e;
        int   n;
        int   i;
        e = use_lit ? lit : model();
        if (abort_at < 0) sb.push_back(e);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("hold_rst_n", bus.core_rst_n, 0);
        chk("hold_done", bus.done, 0);
        chk("hold_flags", {bus.halt_ok, bus.timeout}, 0);
        chk("hold_halt_pc", bus.halt_pc, 0);
        n = 0;
        while (!bus.core_rst_n && n < RST_CYCLES + 8) begin
            bus.start = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        chk("hold_len", n, RST_CYCLES);
        chk("run_rise", bus.running, 1);
        i = 0;
        while (bus.running && i < MAX_CYCLES + 5) begin
            bus.PC_in = seq[(i < MAX_CYCLES) ? i : MAX_CYCLES - 1];
            bus.start = 1'($urandom_range(0, 1));
            if (abort_at >= 0 && i == abort_at) begin
                RST       = 1'b1;
                bus.start = 1'b1;
                @(negedge clk);
                chk("abort_rst_n", bus.core_rst_n, 0);
                chk("abort_running", bus.running, 0);
                chk("abort_cnt", bus.cycle_cnt, 0);
                chk("abort_done", bus.done, 0);
                RST       = 1'b0;
                bus.start = 1'b0;
                repeat (RST_CYCLES + 2) @(negedge clk);
                chk("abort_idle", {bus.running, bus.core_rst_n}, 0);
                return;
            end
            @(negedge clk);
            i++;
        end
        bus.start = 1'b0;
        chk("run_ended", bus.done, 1);
        repeat (gap) begin
            @(negedge clk);
            chk("done_stable", {bus.done, bus.core_rst_n, bus.running}, 3'b110);
            chk("done_cnt", bus.cycle_cnt, e.cnt);
        end
    endtask

    // Monitor: each done rising edge retires one scoreboard entry.
    initial begin
        forever begin
            @(negedge clk);
            if (RST) begin
                done_prev = 1'b0;
            end else begin
                if (bus.done && !done_prev) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_done", 1, 0);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("halt_ok", bus.halt_ok, mon_e.halt_ok);
                        chk("timeout", bus.timeout, mon_e.timeout);
                        chk("halt_pc", bus.halt_pc, mon_e.halt_pc);
                        chk("cycle_cnt", bus.cycle_cnt, mon_e.cnt);
                        chk("done_running", bus.running, 0);
                    end
                end
                chk("flags_exclusive", bus.halt_ok & bus.timeout, 0);
                chk("cnt_le_max", bus.cycle_cnt <= CNT_W'(MAX_CYCLES), 1);
                done_prev = bus.done;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST       = 1'b1;
        bus.start = 1'b1;
        bus.PC_in = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_outputs", {bus.core_rst_n, bus.running, bus.done, bus.halt_ok, bus.timeout}, 0);
        chk("rst_cnt", bus.cycle_cnt, 0);
        chk("rst_halt_pc", bus.halt_pc, 0);
        RST       = 1'b0;
        bus.start = 1'b0;
        repeat (RST_CYCLES + 2) @(negedge clk);
        chk("rst_still_idle", {bus.running, bus.core_rst_n, bus.done}, 0);

        fill_halt_demo();
        do_run(1'b1, mk(1'b1, 1'b0, 12, 7), -1, 0);
        fill_inc(MAX_CYCLES);
        do_run(1'b1, mk(1'b0, 1'b1, 0, MAX_CYCLES), -1, 2);
        fill_near_miss();
        do_run(1'b1, mk(1'b1, 1'b0, 4, 8), -1, 0);
        fill_inc(MAX_CYCLES - HALT_REPEAT - 1);
        do_run(1'b1, mk(1'b1, 1'b0, 4 * (MAX_CYCLES - HALT_REPEAT - 1), MAX_CYCLES), -1, 1);
        fill_inc(MAX_CYCLES - HALT_REPEAT);
        do_run(1'b1, mk(1'b0, 1'b1, 0, MAX_CYCLES), -1, 0);
        fill_inc(MAX_CYCLES);
        do_run(1'b0, mk(1'b0, 1'b0, 0, 0), 50, 0);
        fill_halt_demo();
        do_run(1'b1, mk(1'b1, 1'b0, 12, 7), -1, 1);
        for (int r = 0; r < 10; r++) begin
            fill_rand((r % 3 == 2) ? 1000 : 2 + (r % 2));
            do_run(1'b0, mk(1'b0, 1'b0, 0, 0), -1, $urandom_range(0, 3));
        end
        repeat (2) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/core_run_ctrl.md
# core_run_ctrl

Synthesizable run controller for the single-cycle RISC-V core with cache, replacing fixed-delay bench sequencing with a parametrised start/reset/halt/timeout state machine. It sits between the system clock/reset and the core:
- drives the core's active-low reset;
- watches the core's PC output;
- reports completion, either as halt (PC stuck on a self-loop) or as cycle-budget timeout.

It is used in both simulation benches and FPGA bring-up.

## Interface

Parameters:
- PC_W, 32, width of the monitored PC.
- CNT_W, 32, width of the run-cycle counter.
- RST_CYCLES, 4, cycles the core is held in reset after start. Must be ≥1.
- HALT_REPEAT, 3, consecutive equal-PC comparisons that declare a halt. Must be ≥1.
- MAX_CYCLES, 300, run-cycle budget before timeout. Must satisfy 1 ≤ MAX_CYCLES < 2^CNT_W.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset of this block.
- start  in  1  run request. Sampled only in IDLE and DONE.
- PC_in  in  PC_W  core PC output.
- core_rst_n  out  1  registered active-low reset to the core.
- running  out  1  high in RUN.
- done  out  1  high in DONE.
- halt_ok  out  1  run ended by halt detection. Valid while done.
- timeout  out  1  run ended by budget exhaustion. Valid while done.
- cycle_cnt  out  CNT_W  RUN cycles elapsed in the current or last run.
- halt_pc  out  PC_W  PC at halt detection. 0 on timeout.

## Operation

States: IDLE, HOLD, RUN, DONE.

On RST (synchronous, any state, including mid-run):
- next state IDLE;
- core_rst_n=0;
- running, done, halt_ok, timeout = 0;
- cycle_cnt=0, halt_pc=0;
- internal hold counter, prev_pc, prev_valid and same_cnt cleared.

IDLE:
- core_rst_n=0.
- start=1 → HOLD; clear hold counter.

HOLD:
- core_rst_n=0 for exactly RST_CYCLES cycles, then → RUN.
- On the HOLD→RUN transition: cycle_cnt, same_cnt, prev_valid cleared.
- start ignored.

RUN, every cycle:
- running=1, core_rst_n=1.
- cnt_next = cycle_cnt+1; cycle_cnt ← cnt_next.
- match = prev_valid && (PC_in == prev_pc).
- same_cnt ← match ? same_cnt+1 : 0.
- prev_pc ← PC_in; prev_valid ← 1.
- Halt when match && same_cnt+1 == HALT_REPEAT:
  - → DONE;
  - halt_ok ← 1;
  - halt_pc ← PC_in.
- Otherwise, if cnt_next == MAX_CYCLES:
  - → DONE;
  - timeout ← 1;
  - halt_pc ← 0.
- Halt and budget exhaustion in the same cycle: halt wins, and timeout stays 0.
- start ignored.

DONE:
- done=1; results held stable.
- core_rst_n stays 1, so the core free-runs its self-loop.
- cycle_cnt frozen.
- start=1 → HOLD:
  - core_rst_n ← 0;
  - done, halt_ok and timeout cleared;
  - halt_pc cleared.

Invariants:
- halt_ok and timeout are never both 1.
- cycle_cnt never exceeds MAX_CYCLES.

## Timing

- All outputs are registered; none has a combinational path from inputs.
- start sampled high at edge k (in IDLE or DONE):
  - state is HOLD after edge k;
  - core_rst_n rises after edge k+RST_CYCLES;
  - running=1 from that edge onward.
- First RUN cycle: prev_valid=0, so no comparison is made. Halting requires HALT_REPEAT+1 identical consecutive PC samples.
- Completion registered at edge m: done, halt_ok/timeout, halt_pc and final cycle_cnt are all visible after edge m, and running=0 after edge m.
- Minimum run with PC constant from the first RUN cycle: halt at cycle_cnt = HALT_REPEAT+1.
- start held continuously high: a new run begins one cycle after each DONE entry. done is high for exactly 1 cycle.
- RST asserted together with start: RST wins, and the state stays IDLE.

## Test plan

Defaults throughout: RST_CYCLES=4, HALT_REPEAT=3, MAX_CYCLES=300.

- **Reset values:** RST=1 for 2 cycles.
  - All outputs 0, including core_rst_n=0.
  - start pulse during RST → still IDLE after release.
- **Reset hold length:** start pulse at edge k.
  - core_rst_n low through edge k+3, high after edge k+4.
  - running rises at the same edge.
- **Halt detection:** PC_in sequence 0,4,8,12,12,12,12.
  - done=1, halt_ok=1, timeout=0, halt_pc=12, cycle_cnt=7.
  - Then start → flags clear, core_rst_n=0 for 4 cycles.
- **Timeout:** PC_in increments by 4 every cycle.
  - After 300 RUN cycles: done=1, timeout=1, halt_ok=0, cycle_cnt=300, halt_pc=0.
- **Priority / near-miss:**
  - MAX_CYCLES=7 with the halt sequence above → halt_ok=1, timeout=0.
  - PC 0,8,8,8,4,4,4,4 → halt at 4 with cycle_cnt=8; the interrupted repeat of 8 does not halt.
- **Mid-run reset:** RST=1 at RUN cycle 50.
  - Next cycle: IDLE, core_rst_n=0, cycle_cnt=0.
  - A later start runs cleanly to halt.
